// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if
// Purpose : bundles the hazard-detection inputs from the pipeline and the
//           control/status outputs of the hazard controller.
// Signals : ID_Rn/ID_Rm/ID_uses_Rn/ID_uses_Rm   - source operands of the ID instruction
//           EX_Load_Inst/EX_Rd                  - load flag and destination of EX instruction
//           MEM_mem_enable/mem_ready            - data-memory access and its completion
//           branch_taken                        - taken branch resolved in ID
//           PC_LE..MEM_WB_LE                    - pipeline register load enables
//           NOP_sel/IF_ID_flush                 - bubble insert / IF-ID clear
//           hz_state/stall_cycles/mem_timeout   - status
// Modports: master = pipeline side, slave = hazard controller.
interface pipeline_hazard_controller_if;
    logic [3:0]  ID_Rn;
    logic [3:0]  ID_Rm;
    logic        ID_uses_Rn;
    logic        ID_uses_Rm;
    logic        EX_Load_Inst;
    logic [3:0]  EX_Rd;
    logic        MEM_mem_enable;
    logic        mem_ready;
    logic        branch_taken;

    logic        PC_LE;
    logic        IF_ID_LE;
    logic        ID_EX_LE;
    logic        EX_MEM_LE;
    logic        MEM_WB_LE;
    logic        NOP_sel;
    logic        IF_ID_flush;
    logic [1:0]  hz_state;
    logic [15:0] stall_cycles;
    logic        mem_timeout;

    modport master (
        output ID_Rn, ID_Rm, ID_uses_Rn, ID_uses_Rm, EX_Load_Inst, EX_Rd,
               MEM_mem_enable, mem_ready, branch_taken,
        input  PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE, NOP_sel, IF_ID_flush,
               hz_state, stall_cycles, mem_timeout
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_uses_Rn, ID_uses_Rm, EX_Load_Inst, EX_Rd,
               MEM_mem_enable, mem_ready, branch_taken,
        output PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE, NOP_sel, IF_ID_flush,
               hz_state, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Purpose : detects memory-wait, load-use and taken-branch hazards and drives
//           pipeline load enables, bubble insertion and IF/ID flush with
//           fixed priority memory-wait > load-use > branch.
// Ports   : clk     - clock, all state on rising edge
//           reset_n - synchronous active-low reset
//           hz      - hazard interface (slave side), see pipeline_hazard_controller_if
module pipeline_hazard_controller (
    input  logic                          clk,
    input  logic                          reset_n,
    pipeline_hazard_controller_if.slave   hz
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLdStall = 2'b01,
        StMemWait = 2'b10,
        StFlush   = 2'b11
    } hz_state_e;

    hz_state_e   r_state;
    hz_state_e   w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_cycles;
    logic        r_mem_timeout;

    logic w_mw;
    logic w_lu;
    logic w_br;
    logic w_pc_le;
    logic w_if_id_le;
    logic w_back_le;   // shared by ID/EX, EX/MEM, MEM/WB
    logic w_nop_sel;
    logic w_flush;

    assign w_mw = hz.MEM_mem_enable & ~hz.mem_ready;
    assign w_lu = hz.EX_Load_Inst &
                  ((hz.ID_uses_Rn & (hz.ID_Rn == hz.EX_Rd)) |
                   (hz.ID_uses_Rm & (hz.ID_Rm == hz.EX_Rd)));
    assign w_br = hz.branch_taken;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state follows the highest-priority condition seen this cycle
    always_comb begin
        w_state_next = StRun;
        if (w_mw) begin
            w_state_next = StMemWait;
        end else if (w_lu) begin
            w_state_next = StLdStall;
        end else if (w_br) begin
            w_state_next = StFlush;
        end
    end

    // Control outputs are same-cycle; an unresolved load-use held behind a
    // memory freeze simply re-evaluates once the freeze lifts.
    always_comb begin
        w_pc_le    = 1'b1;
        w_if_id_le = 1'b1;
        w_back_le  = 1'b1;
        w_nop_sel  = 1'b0;
        w_flush    = 1'b0;
        if (!reset_n) begin
            // Fill the pipeline with NOPs while held in reset
            w_nop_sel = 1'b1;
            w_flush   = 1'b1;
        end else if (w_mw) begin
            w_pc_le    = 1'b0;
            w_if_id_le = 1'b0;
            w_back_le  = 1'b0;
        end else if (w_lu) begin
            w_pc_le    = 1'b0;
            w_if_id_le = 1'b0;
            w_nop_sel  = 1'b1;
        end else if (w_br) begin
            w_flush = 1'b1;
        end
    end

    // Wait counter, timeout flag and stall counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt     <= 8'd0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (w_mw) begin
                if (r_wait_cnt != 8'hFF) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end else begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (!w_pc_le && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign hz.PC_LE        = w_pc_le;
    assign hz.IF_ID_LE     = w_if_id_le;
    assign hz.ID_EX_LE     = w_back_le;
    assign hz.EX_MEM_LE    = w_back_le;
    assign hz.MEM_WB_LE    = w_back_le;
    assign hz.NOP_sel      = w_nop_sel;
    assign hz.IF_ID_flush  = w_flush;
    assign hz.hz_state     = r_state;
    assign hz.stall_cycles = r_stall_cycles;
    assign hz.mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Purpose : self-checking bench for pipeline_hazard_controller; directed
//           scenarios plus random stimulus checked against a rule-level model.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if hz_if ();

    pipeline_hazard_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_state   = 0;
    int m_stall   = 0;
    int m_wait    = 0;
    int m_timeout = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int rn, input int rm, input bit urn, input bit urm,
                          input bit ld, input int rd, input bit men, input bit rdy,
                          input bit br);
        hz_if.ID_Rn          = 4'(rn);
        hz_if.ID_Rm          = 4'(rm);
        hz_if.ID_uses_Rn     = urn;
        hz_if.ID_uses_Rm     = urm;
        hz_if.EX_Load_Inst   = ld;
        hz_if.EX_Rd          = 4'(rd);
        hz_if.MEM_mem_enable = men;
        hz_if.mem_ready      = rdy;
        hz_if.branch_taken   = br;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // Inputs are applied just after a rising edge; this checks mid-cycle,
    // then advances the model across the next edge.
    task automatic step();
        int   cond;
        bit   mw;
        bit   lu;
        logic [4:0] le;
        logic nop;
        logic fl;
        int   n_state;
        int   n_stall;
        int   n_wait;
        int   n_timeout;
        int   cond_to_state [4] = '{0, 3, 1, 2};  // none, BR, LU, MW
        #4;
        mw = hz_if.MEM_mem_enable && !hz_if.mem_ready;
        lu = hz_if.EX_Load_Inst &&
             ((hz_if.ID_uses_Rn && hz_if.ID_Rn == hz_if.EX_Rd) ||
              (hz_if.ID_uses_Rm && hz_if.ID_Rm == hz_if.EX_Rd));
        cond = mw ? 3 : lu ? 2 : hz_if.branch_taken ? 1 : 0;
        // le = {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
        if (!reset_n) begin
            le = 5'b11111; nop = 1'b1; fl = 1'b1;
        end else begin
            case (cond)
                3:       begin le = 5'b00000; nop = 1'b0; fl = 1'b0; end
                2:       begin le = 5'b00111; nop = 1'b1; fl = 1'b0; end
                1:       begin le = 5'b11111; nop = 1'b0; fl = 1'b1; end
                default: begin le = 5'b11111; nop = 1'b0; fl = 1'b0; end
            endcase
        end
        check("le", {27'd0, hz_if.PC_LE, hz_if.IF_ID_LE, hz_if.ID_EX_LE, hz_if.EX_MEM_LE,
                     hz_if.MEM_WB_LE}, {27'd0, le});
        check("nop_sel", {31'd0, hz_if.NOP_sel}, {31'd0, nop});
        check("flush", {31'd0, hz_if.IF_ID_flush}, {31'd0, fl});
        check("hz_state", {30'd0, hz_if.hz_state}, 32'(m_state));
        check("stall_cycles", {16'd0, hz_if.stall_cycles}, 32'(m_stall));
        check("mem_timeout", {31'd0, hz_if.mem_timeout}, 32'(m_timeout));
        if (reset_n) begin
            check("nop_flush_excl", {31'd0, hz_if.NOP_sel & hz_if.IF_ID_flush}, 32'd0);
        end
        if (!reset_n) begin
            n_state = 0; n_stall = 0; n_wait = 0; n_timeout = 0;
        end else begin
            n_state   = cond_to_state[cond];
            n_stall   = (le[4] == 1'b0 && m_stall < 65535) ? m_stall + 1 : m_stall;
            n_timeout = (mw && m_wait == 255) ? 1 : m_timeout;
            n_wait    = mw ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
        end
        @(posedge clk);
        #1;
        m_state = n_state; m_stall = n_stall; m_wait = n_wait; m_timeout = n_timeout;
    endtask

    initial begin
        int s0;
        reset_n = 1'b0;
        set_idle();
        @(posedge clk);
        #1;
        step();                      // outputs while held in reset
        check("rst_state", {30'd0, hz_if.hz_state}, 32'd0);
        check("rst_stall", {16'd0, hz_if.stall_cycles}, 32'd0);
        reset_n = 1'b1;

        // Load-use on Rn: one bubble
        set_in(3, 0, 1, 0, 1, 3, 0, 1, 0);
        step();
        check("lu_state", {30'd0, hz_if.hz_state}, 32'd1);
        check("lu_stall", {16'd0, hz_if.stall_cycles}, 32'd1);
        set_idle();
        step();

        // No false hazard
        set_in(3, 0, 0, 0, 1, 3, 0, 1, 0);
        step();
        set_in(0, 3, 0, 0, 1, 3, 0, 1, 0);
        step();
        check("nofalse_state", {30'd0, hz_if.hz_state}, 32'd0);

        // Memory wait: 3 frozen cycles, release on 4th
        s0 = m_stall;
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) step();
        check("mw_state", {30'd0, hz_if.hz_state}, 32'd2);
        check("mw_stall", {16'd0, hz_if.stall_cycles}, 32'(s0 + 3));
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();

        // Priority: MW+LU+BR, then LU, then BR
        set_in(5, 0, 1, 0, 1, 5, 1, 0, 1);
        step();
        set_in(5, 0, 1, 0, 1, 5, 0, 1, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        check("br_state", {30'd0, hz_if.hz_state}, 32'd3);
        set_idle();
        step();

        // Random stimulus with occasional reset
        for (int i = 0; i < 2000; i++) begin
            reset_n = ($urandom_range(63) != 0);
            set_in($urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(3), ($urandom_range(9) < 3),
                   1'($urandom), ($urandom_range(3) == 0));
            step();
        end
        reset_n = 1'b1;

        // Timeout: 300 wait cycles then ready
        reset_n = 1'b0;
        set_idle();
        step();
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (255) step();
        check("to_before", {31'd0, hz_if.mem_timeout}, 32'd0);
        step();
        check("to_set", {31'd0, hz_if.mem_timeout}, 32'd1);
        repeat (44) step();
        set_idle();
        repeat (3) step();
        check("to_sticky", {31'd0, hz_if.mem_timeout}, 32'd1);

        // Stall counter saturation
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (65300) step();
        check("stall_sat", {16'd0, hz_if.stall_cycles}, 32'hFFFF);

        // Reset in the middle of a memory wait
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        set_idle();
        step();
        check("rst_mw_state", {30'd0, hz_if.hz_state}, 32'd0);
        check("rst_mw_stall", {16'd0, hz_if.stall_cycles}, 32'd0);
        check("rst_mw_to", {31'd0, hz_if.mem_timeout}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-003 SHALL: ID_Rn, ID_Rm  input  4 each  source register numbers of the instruction in ID.
REQ-004 SHALL: ID_uses_Rn, ID_uses_Rm  input  1 each  1 = the matching source register is read.
REQ-005 SHALL: EX_Load_Inst  input  1; EX_Rd  input  4  load flag and destination of the instruction in EX.
REQ-006 SHALL: MEM_mem_enable  input  1; mem_ready  input  1  data-memory access active in MEM / access completes this cycle.
REQ-007 SHALL: branch_taken  input  1  taken B/BL resolved in ID this cycle.
REQ-008 SHALL: PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_LE  output  1 each  pipeline register load enables.
REQ-009 SHALL: NOP_sel  output  1  forces all-zero (NOP) control word into ID/EX.
REQ-010 SHALL: IF_ID_flush  output  1  clears IF/ID to instruction 0x00000000.
REQ-011 SHALL: hz_state  output  2  registered state: RUN=00, LDSTALL=01, MEMWAIT=10, FLUSH=11.
REQ-012 SHALL: stall_cycles  output  16  saturating count of cycles with PC_LE=0.
REQ-013 SHALL: mem_timeout  output  1  sticky error flag.

Function
REQ-014 SHALL: define conditions: MW = MEM_mem_enable & ~mem_ready; LU = EX_Load_Inst & ((ID_uses_Rn & ID_Rn==EX_Rd) | (ID_uses_Rm & ID_Rm==EX_Rd)); BR = branch_taken.
REQ-015 SHALL: give control outputs combinationally (same cycle) from MW/LU/BR, fixed priority MW > LU > BR.
REQ-016 SHALL: on MW, drive all five LE = 0, NOP_sel = 0, IF_ID_flush = 0 (freeze); next hz_state = MEMWAIT.
REQ-017 SHALL: on LU without MW, drive PC_LE = IF_ID_LE = 0, NOP_sel = 1, other LE = 1, flush = 0; next hz_state = LDSTALL; exactly one bubble per load-use pair.
REQ-018 SHALL: on BR without MW/LU, drive IF_ID_flush = 1, all LE = 1, NOP_sel = 0; next hz_state = FLUSH.
REQ-019 SHALL: with no condition, drive all LE = 1, NOP_sel = 0, flush = 0; next hz_state = RUN.
REQ-020 SHALL: leave MEMWAIT to next-condition state on the first cycle mem_ready = 1; that cycle all LE = 1.
REQ-021 SHALL: keep 8-bit wait_cnt, cleared whenever MW = 0, incremented each cycle MW = 1, saturating at 255.
REQ-022 SHALL: set mem_timeout on the edge where MW = 1 and wait_cnt = 255 (256th consecutive wait cycle); held until reset; no effect on freeze.
REQ-023 SHALL: increment stall_cycles on each edge where PC_LE = 0, saturating at 0xFFFF (no wrap).
REQ-024 SHALL: treat LU suppressed by MW as still pending: re-evaluated after freeze, since EX contents are unchanged.
REQ-025 SHALL: suppress BR flush while LU stalls; branch re-resolves next cycle.
REQ-026 SHALL: never assert IF_ID_flush and NOP_sel in the same cycle.

Reset
REQ-027 SHALL: on a clk edge with reset_n = 0, set hz_state = RUN, stall_cycles = 0, wait_cnt = 0, mem_timeout = 0.
REQ-028 SHALL: while reset_n = 0, force all LE = 1, NOP_sel = 1, IF_ID_flush = 1 so the pipeline fills with NOPs; stall_cycles does not count.
REQ-029 SHALL: abort any MEMWAIT/LDSTALL in progress on reset with no residual stall after reset_n rises.

Verification
REQ-030 SHALL: load-use: EX_Load_Inst=1, EX_Rd=3, ID_Rn=3, ID_uses_Rn=1 -> PC_LE=IF_ID_LE=0, NOP_sel=1 one cycle; hz_state=01; stall_cycles 0->1.
REQ-031 SHALL: no false hazard: same but ID_uses_Rn=0 or ID_Rm=3 with ID_uses_Rm=0 -> all LE=1, NOP_sel=0, hz_state=00.
REQ-032 SHALL: memory wait: MEM_mem_enable=1, mem_ready low 3 cycles then high -> 3 frozen cycles, hz_state=10, stall_cycles=3, release on 4th.
REQ-033 SHALL: priority: MW, LU, BR all 1 -> freeze only, flush=0, NOP_sel=0; then LU alone -> one bubble; then BR -> IF_ID_flush=1, hz_state=11.
REQ-034 SHALL: timeout/saturation: mem_ready low 300 cycles -> mem_timeout=1 after 256th wait cycle, stays 1 after ready; preload near 0xFFFF -> holds 0xFFFF.
REQ-035 SHALL: reset mid-MEMWAIT: reset_n=0 one edge -> hz_state=00, counters 0, mem_timeout 0, outputs per REQ-028.
